// File: rtl/commit_trace_buf_if.sv
// Commit-trace capture/drain bundle: WB/CSR commit inputs, trace stream and status.
// The slave modport is the trace buffer; the master modport is the core/consumer side.
interface commit_trace_buf_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic                     trace_en;
  logic                     flush;
  logic [31:0]              wb_pc;
  logic [3:0]               wb_rf_wen;
  logic [4:0]               wb_rf_wnum;
  logic [31:0]              wb_rf_wdata;
  logic                     csr_we;
  logic [11:0]              csr_waddr;
  logic [31:0]              csr_wdata;
  logic                     trace_valid;
  logic                     trace_ready;
  logic [77:0]              trace_data;
  logic [$clog2(DEPTH):0]   trace_count;
  logic                     overflow;
  logic [CNT_W-1:0]         drop_cnt;

  modport master (
    output trace_en, flush, wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata,
           csr_we, csr_waddr, csr_wdata, trace_ready,
    input  trace_valid, trace_data, trace_count, overflow, drop_cnt
  );

  modport slave (
    input  trace_en, flush, wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata,
           csr_we, csr_waddr, csr_wdata, trace_ready,
    output trace_valid, trace_data, trace_count, overflow, drop_cnt
  );
endinterface

// File: rtl/commit_trace_buf.sv
// Commit trace FIFO: captures GPR/CSR writeback records (up to two per cycle),
// drops whole cycles atomically when space is short, and counts drops.
module commit_trace_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  commit_trace_buf_if.slave trc
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned FREE_W = PTR_W + 2;
  localparam int unsigned SUM_W  = CNT_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             ovf_q;
  logic [CNT_W-1:0] drop_q;
  logic [77:0]      mem [DEPTH];

  logic             gpr_ev;
  logic             csr_ev;
  logic [1:0]       n_ev;
  logic [1:0]       push_n;
  logic             pop;
  logic [FREE_W-1:0] free_slots;
  logic             accept;
  logic             push;
  logic             drop;
  logic [77:0]      rec0;
  logic [77:0]      rec1;
  logic [SUM_W-1:0] drop_sum;

  always_comb begin
    gpr_ev     = trc.trace_en && (trc.wb_rf_wen != '0) && (trc.wb_rf_wnum != '0);
    csr_ev     = trc.trace_en && trc.csr_we;
    n_ev       = {1'b0, gpr_ev} + {1'b0, csr_ev};
    pop        = (count != '0) && trc.trace_ready;
    // The slot freed by a same-cycle pop is usable, so a full FIFO still takes one record.
    free_slots = FREE_W'(DEPTH) - {1'b0, count} + FREE_W'(pop);
    accept     = FREE_W'(n_ev) <= free_slots;
    push       = accept && (n_ev != 2'd0);
    drop       = !accept;
    push_n     = push ? n_ev : 2'd0;
    // GPR record always takes the first slot when present.
    rec0       = gpr_ev ? {2'b00, 7'b0, trc.wb_rf_wnum, trc.wb_pc, trc.wb_rf_wdata}
                        : {2'b01, trc.csr_waddr, trc.wb_pc, trc.csr_wdata};
    rec1       = {2'b01, trc.csr_waddr, trc.wb_pc, trc.csr_wdata};
    drop_sum   = {1'b0, drop_q} + SUM_W'(n_ev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (trc.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(n_ev);
      count <= count + OCC_W'(push_n) - OCC_W'(pop);
      if (drop) begin
        ovf_q  <= 1'b1;
        drop_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !trc.flush && push) begin
      mem[wr_ptr] <= rec0;
      if (n_ev == 2'd2) mem[wr_ptr + PTR_W'(1)] <= rec1;
    end
  end

  assign trc.trace_valid = (count != '0);
  assign trc.trace_data  = mem[rd_ptr];
  assign trc.trace_count = count;
  assign trc.overflow    = ovf_q;
  assign trc.drop_cnt    = drop_q;
endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench for commit_trace_buf: records are queued when driven and
// compared against trace_data as the consumer pops them.
module tb_commit_trace_buf;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_buf_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) trc ();
  commit_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .trc (trc)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [77:0] sb[$];
  logic        m_ovf  = 1'b0;
  int unsigned m_drop = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    trc.trace_en    = 1'b1;
    trc.flush       = 1'b0;
    trc.wb_pc       = '0;
    trc.wb_rf_wen   = '0;
    trc.wb_rf_wnum  = '0;
    trc.wb_rf_wdata = '0;
    trc.csr_we      = 1'b0;
    trc.csr_waddr   = '0;
    trc.csr_wdata   = '0;
  endtask

  task automatic set_gpr(input logic [4:0] num, input logic [31:0] data, input logic [31:0] pc);
    trc.wb_rf_wen   = 4'hf;
    trc.wb_rf_wnum  = num;
    trc.wb_rf_wdata = data;
    trc.wb_pc       = pc;
  endtask

  task automatic set_csr(input logic [11:0] addr, input logic [31:0] data);
    trc.csr_we    = 1'b1;
    trc.csr_waddr = addr;
    trc.csr_wdata = data;
  endtask

  // Check state, apply the model for the currently driven inputs, advance one clock.
  task automatic cycle();
    logic gpr, csr, pop;
    int   n_ev, free;
    check("count", trc.trace_count, sb.size());
    check("valid", trc.trace_valid, sb.size() != 0);
    check("overflow", trc.overflow, m_ovf);
    check("drop_cnt", trc.drop_cnt, m_drop);
    if (sb.size() != 0) check("head", trc.trace_data, sb[0]);
    pop  = (sb.size() != 0) && trc.trace_ready;
    gpr  = trc.trace_en && (trc.wb_rf_wen != 0) && (trc.wb_rf_wnum != 0);
    csr  = trc.trace_en && trc.csr_we;
    n_ev = int'(gpr) + int'(csr);
    free = int'(DEPTH) - sb.size() + int'(pop);
    if (rst) begin
      sb.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (trc.flush) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (n_ev > 0 && n_ev <= free) begin
        if (gpr) sb.push_back({2'b00, 7'b0, trc.wb_rf_wnum, trc.wb_pc, trc.wb_rf_wdata});
        if (csr) sb.push_back({2'b01, trc.csr_waddr, trc.wb_pc, trc.csr_wdata});
      end else if (n_ev > 0) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + n_ev > DMAX) ? DMAX : m_drop + n_ev;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      trc.trace_ready = 1'b0;
      set_gpr(5'(i % 31 + 1), 32'h1000 + i, 32'h8000_1000 + 4 * i);
      cycle();
    end
    drive_idle();
  endtask

  initial begin
    logic [77:0] exp37;
    exp37 = {2'b00, 12'h005, 32'h8000_0010, 32'h0000_1234};

    drive_idle();
    trc.trace_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Single GPR event, consumer ready
    set_gpr(5'd5, 32'h1234, 32'h8000_0010);
    trc.trace_ready = 1'b1;
    cycle();
    drive_idle();
    check("req037_data", trc.trace_data, exp37);
    check("req037_valid", trc.trace_valid, 1'b1);
    cycle();
    check("req037_popped", trc.trace_count, 0);

    // Dual event: GPR then CSR
    set_gpr(5'd3, 32'hAAAA_0003, 32'h8000_0020);
    set_csr(12'h305, 32'h0000_0100);
    trc.trace_ready = 1'b0;
    cycle();
    drive_idle();
    check("req038_count", trc.trace_count, 2);
    trc.trace_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    // Fill to full, then one more event is dropped
    fill(DEPTH);
    check("req039_full", trc.trace_count, DEPTH);
    trc.trace_ready = 1'b0;
    set_gpr(5'd9, 32'h9999, 32'h8000_2000);
    cycle();
    drive_idle();
    check("req039_ovf", trc.overflow, 1'b1);
    check("req039_drop", trc.drop_cnt, 1);
    check("req039_count", trc.trace_count, DEPTH);

    // Full with pop: dual dropped, single accepted
    trc.trace_ready = 1'b1;
    set_gpr(5'd10, 32'hA, 32'h8000_3000);
    set_csr(12'h341, 32'hB);
    cycle();
    drive_idle();
    check("req040_drop2", trc.drop_cnt, 3);
    check("req040_count7", trc.trace_count, DEPTH - 1);
    fill(1);
    trc.trace_ready = 1'b1;
    set_gpr(5'd11, 32'hC, 32'h8000_3004);
    cycle();
    drive_idle();
    check("req040_count8", trc.trace_count, DEPTH);
    check("req040_drop_hold", trc.drop_cnt, 3);

    // No capture for x0 or trace_en=0; then flush at count 5
    trc.trace_ready = 1'b0;
    set_gpr(5'd0, 32'hDEAD, 32'h8000_4000);
    cycle();
    drive_idle();
    trc.trace_en = 1'b0;
    set_gpr(5'd7, 32'hBEEF, 32'h8000_4004);
    set_csr(12'h300, 32'h8);
    trc.trace_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    drive_idle();
    trc.trace_ready = 1'b0;
    check("req041_count5", trc.trace_count, 5);
    trc.flush = 1'b1;
    trc.trace_ready = 1'b1;
    set_gpr(5'd8, 32'h8, 32'h8000_5000);
    cycle();
    drive_idle();
    check("req041_flush", trc.trace_count, 0);
    check("req041_ovf", trc.overflow, 1'b1);
    check("req041_drop", trc.drop_cnt, 3);

    // Saturate the drop counter
    fill(DEPTH);
    for (int i = 0; i < 8; i++) begin
      trc.trace_ready = 1'b0;
      set_gpr(5'd12, 32'h12, 32'h8000_6000);
      set_csr(12'h7c0, 32'h34);
      cycle();
    end
    drive_idle();
    check("drop_sat", trc.drop_cnt, DMAX);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_idle();
      trc.trace_en = ($urandom_range(0, 9) != 0);
      trc.flush    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_gpr(5'($urandom_range(0, 31)), $urandom, $urandom);
        trc.wb_rf_wen = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 2) == 0) set_csr(12'($urandom), $urandom);
      trc.trace_ready = ($urandom_range(0, 4) < 3);
      cycle();
    end
    drive_idle();

    // Reset mid-drain at count 3
    trc.flush = 1'b1;
    cycle();
    trc.flush = 1'b0;
    fill(5);
    trc.trace_ready = 1'b1;
    cycle();
    cycle();
    check("req042_count3", trc.trace_count, 3);
    rst = 1'b1;
    set_gpr(5'd4, 32'h44, 32'h8000_7000);
    cycle();
    rst = 1'b0;
    drive_idle();
    check("req042_count", trc.trace_count, 0);
    check("req042_valid", trc.trace_valid, 1'b0);
    check("req042_drop", trc.drop_cnt, 0);
    check("req042_ovf", trc.overflow, 1'b0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
